// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single 8x16 level-sensitive RAM.
// One RAM access per two cycles; every RAM-side signal comes straight from a register.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic PORT_A  = 1'b0;
  localparam logic PORT_B  = 1'b1;
  localparam logic W_FIXED = (FIXED_PRIO != 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_last;
  logic              r_en;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_busy;

  logic              w_pick_a;
  logic              w_pick_b;
  logic              w_rr_nxt;
  logic              w_en_nxt;
  logic              w_rw_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_din_nxt;
  logic              w_a_gnt_nxt;
  logic              w_b_gnt_nxt;
  logic              w_a_rvalid_nxt;
  logic              w_b_rvalid_nxt;
  logic [DATA_W-1:0] w_a_rdata_nxt;
  logic [DATA_W-1:0] w_b_rdata_nxt;

  // A wins a tie under fixed priority or when B was served last.
  assign w_pick_a = a_req & (~b_req | W_FIXED | (r_rr_last == PORT_B));
  assign w_pick_b = b_req & ~w_pick_a;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (a_req | b_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered command/response outputs
  always_comb begin
    w_rr_nxt       = r_rr_last;
    w_en_nxt       = r_en;
    w_rw_nxt       = r_rw;
    w_addr_nxt     = r_addr;
    w_din_nxt      = r_din;
    w_a_gnt_nxt    = 1'b0;
    w_b_gnt_nxt    = 1'b0;
    w_a_rvalid_nxt = 1'b0;
    w_b_rvalid_nxt = 1'b0;
    w_a_rdata_nxt  = r_a_rdata;
    w_b_rdata_nxt  = r_b_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_pick_a) begin
          w_en_nxt    = 1'b1;
          w_rw_nxt    = ~a_we;
          w_addr_nxt  = a_addr;
          w_din_nxt   = a_wdata;
          w_a_gnt_nxt = 1'b1;
          w_rr_nxt    = PORT_A;
        end else if (w_pick_b) begin
          w_en_nxt    = 1'b1;
          w_rw_nxt    = ~b_we;
          w_addr_nxt  = b_addr;
          w_din_nxt   = b_wdata;
          w_b_gnt_nxt = 1'b1;
          w_rr_nxt    = PORT_B;
        end
      end
      S_ACCESS: begin
        // Return to a safe read default; r_rr_last still names the port being served.
        w_en_nxt = 1'b0;
        w_rw_nxt = 1'b1;
        if (r_rw) begin
          if (r_rr_last == PORT_A) begin
            w_a_rvalid_nxt = 1'b1;
            w_a_rdata_nxt  = ram_dout;
          end else begin
            w_b_rvalid_nxt = 1'b1;
            w_b_rdata_nxt  = ram_dout;
          end
        end
      end
      default: begin
        w_en_nxt = 1'b0;
        w_rw_nxt = 1'b1;
      end
    endcase
  end

  // Output and arbitration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last  <= PORT_B;
      r_en       <= 1'b0;
      r_rw       <= 1'b1;
      r_addr     <= '0;
      r_din      <= '0;
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_rr_last  <= w_rr_nxt;
      r_en       <= w_en_nxt;
      r_rw       <= w_rw_nxt;
      r_addr     <= w_addr_nxt;
      r_din      <= w_din_nxt;
      r_a_gnt    <= w_a_gnt_nxt;
      r_b_gnt    <= w_b_gnt_nxt;
      r_a_rvalid <= w_a_rvalid_nxt;
      r_b_rvalid <= w_b_rvalid_nxt;
      r_a_rdata  <= w_a_rdata_nxt;
      r_b_rdata  <= w_b_rdata_nxt;
      r_busy     <= (w_state_nxt == S_ACCESS);
    end
  end

  assign a_gnt       = r_a_gnt;
  assign b_gnt       = r_b_gnt;
  assign a_rvalid    = r_a_rvalid;
  assign b_rvalid    = r_b_rvalid;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign ram_enable  = r_en;
  assign ram_rw      = r_rw;
  assign ram_address = r_addr;
  assign ram_din     = r_din;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, priority/reset sequences,
// and random two-port traffic checked against a reference memory.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_enable, ram_rw, busy;
  logic [2:0]  ram_address;
  logic [15:0] ram_din, ram_dout;

  logic        f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid;
  logic [15:0] f_a_rdata, f_b_rdata;
  logic        f_en, f_rw, f_busy;
  logic [2:0]  f_addr;
  logic [15:0] f_din;
  logic [15:0] f_dout;

  logic        mem_clr;
  logic [15:0] mem [8];
  logic [15:0] ref_mem [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(3), .DATA_W(16), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_address(ram_address),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  ram_port_arbiter #(.ADDR_W(3), .DATA_W(16), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
    .ram_enable(f_en), .ram_rw(f_rw), .ram_address(f_addr),
    .ram_din(f_din), .ram_dout(f_dout), .busy(f_busy)
  );

  // Behavioural RAM: level-sensitive read, write lands at the end of the enabled cycle.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
    end else if (ram_enable && !ram_rw) begin
      mem[ram_address] <= ram_din;
    end
  end
  assign ram_dout = (ram_enable && ram_rw) ? mem[ram_address] : 16'hDEAD;
  assign f_dout   = 16'h0000;

  typedef struct {
    logic ar; logic aw; logic [2:0] aa; logic [15:0] ad;
    logic br; logic bw; logic [2:0] ba; logic [15:0] bd;
    logic eag; logic ebg; logic earv; logic ebrv;
    logic [15:0] eard; logic [15:0] ebrd;
    logic een; logic erw; logic [2:0] eaddr; logic [15:0] edin; logic ebusy;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [2:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic [2:0] ba, input logic [15:0] bd,
    input logic eag, input logic ebg, input logic earv, input logic ebrv,
    input logic [15:0] eard, input logic [15:0] ebrd,
    input logic een, input logic erw, input logic [2:0] eaddr,
    input logic [15:0] edin, input logic ebusy);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.earv = earv; v.ebrv = ebrv;
    v.eard = eard; v.ebrd = ebrd;
    v.een = een; v.erw = erw; v.eaddr = eaddr; v.edin = edin; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [2:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " a_gnt"},    32'(a_gnt), 0);
    chk({tag, " b_gnt"},    32'(b_gnt), 0);
    chk({tag, " a_rvalid"}, 32'(a_rvalid), 0);
    chk({tag, " b_rvalid"}, 32'(b_rvalid), 0);
    chk({tag, " a_rdata"},  32'(a_rdata), 0);
    chk({tag, " b_rdata"},  32'(b_rdata), 0);
    chk({tag, " ram_enable"}, 32'(ram_enable), 0);
    chk({tag, " ram_rw"},   32'(ram_rw), 1);
    chk({tag, " ram_address"}, 32'(ram_address), 0);
    chk({tag, " ram_din"},  32'(ram_din), 0);
    chk({tag, " busy"},     32'(busy), 0);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_fa, cnt_fb, ops, iters;
    logic tb_rr;
    logic ar, aw, br, bw, pa, pb, rd_op;
    logic [2:0]  aa, ba;
    logic [15:0] ad, bd, exp_rd;

    //     ar aw aa  ad       br bw ba  bd       | ag bg arv brv ard      brd      en rw ad  din      busy
    vecs[0]  = mk(1,1,3,16'hBEEF, 0,0,0,16'h0,    1,0,0,0, 16'h0,    16'h0,    1,0,3,16'hBEEF,1);
    vecs[1]  = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,0,0, 16'h0,    16'h0,    0,1,3,16'hBEEF,0);
    vecs[2]  = mk(1,0,3,16'hBEEF, 0,0,0,16'h0,    1,0,0,0, 16'h0,    16'h0,    1,1,3,16'hBEEF,1);
    vecs[3]  = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,1,0, 16'hBEEF, 16'h0,    0,1,3,16'hBEEF,0);
    vecs[4]  = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,0,0, 16'hBEEF, 16'h0,    0,1,3,16'hBEEF,0);
    vecs[5]  = mk(0,0,0,16'h0,    1,1,5,16'h5A5A, 0,1,0,0, 16'hBEEF, 16'h0,    1,0,5,16'h5A5A,1);
    vecs[6]  = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,0,0, 16'hBEEF, 16'h0,    0,1,5,16'h5A5A,0);
    vecs[7]  = mk(1,0,3,16'h5A5A, 1,0,5,16'h5A5A, 1,0,0,0, 16'hBEEF, 16'h0,    1,1,3,16'h5A5A,1);
    vecs[8]  = mk(1,0,3,16'h5A5A, 1,0,5,16'h5A5A, 0,0,1,0, 16'hBEEF, 16'h0,    0,1,3,16'h5A5A,0);
    vecs[9]  = mk(1,0,3,16'h5A5A, 1,0,5,16'h5A5A, 0,1,0,0, 16'hBEEF, 16'h0,    1,1,5,16'h5A5A,1);
    vecs[10] = mk(1,0,3,16'h5A5A, 1,0,5,16'h5A5A, 0,0,0,1, 16'hBEEF, 16'h5A5A, 0,1,5,16'h5A5A,0);
    vecs[11] = mk(1,0,3,16'h5A5A, 1,0,5,16'h5A5A, 1,0,0,0, 16'hBEEF, 16'h5A5A, 1,1,3,16'h5A5A,1);
    vecs[12] = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,1,0, 16'hBEEF, 16'h5A5A, 0,1,3,16'h5A5A,0);
    vecs[13] = mk(0,0,0,16'h0,    1,0,5,16'h5A5A, 0,1,0,0, 16'hBEEF, 16'h5A5A, 1,1,5,16'h5A5A,1);
    vecs[14] = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,0,1, 16'hBEEF, 16'h5A5A, 0,1,5,16'h5A5A,0);
    vecs[15] = mk(1,0,7,16'h5A5A, 1,1,7,16'h1234, 1,0,0,0, 16'hBEEF, 16'h5A5A, 1,1,7,16'h5A5A,1);
    vecs[16] = mk(0,0,0,16'h0,    1,1,7,16'h1234, 0,0,1,0, 16'h0000, 16'h5A5A, 0,1,7,16'h5A5A,0);
    vecs[17] = mk(0,0,0,16'h0,    1,1,7,16'h1234, 0,1,0,0, 16'h0000, 16'h5A5A, 1,0,7,16'h1234,1);
    vecs[18] = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,0,0, 16'h0000, 16'h5A5A, 0,1,7,16'h1234,0);
    vecs[19] = mk(1,0,7,16'h1234, 0,0,0,16'h0,    1,0,0,0, 16'h0000, 16'h5A5A, 1,1,7,16'h1234,1);
    vecs[20] = mk(0,0,0,16'h0,    0,0,0,16'h0,    0,0,1,0, 16'h1234, 16'h5A5A, 0,1,7,16'h1234,0);

    rst = 1'b1;
    mem_clr = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;
    mem_clr = 1'b0;

    // Directed table: write/read on A, alternating ties, same-address read-before-write
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      step();
      chk($sformatf("v%0d a_gnt", i),    32'(a_gnt),    32'(vecs[i].eag));
      chk($sformatf("v%0d b_gnt", i),    32'(b_gnt),    32'(vecs[i].ebg));
      chk($sformatf("v%0d a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].earv));
      chk($sformatf("v%0d b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].ebrv));
      chk($sformatf("v%0d a_rdata", i),  32'(a_rdata),  32'(vecs[i].eard));
      chk($sformatf("v%0d b_rdata", i),  32'(b_rdata),  32'(vecs[i].ebrd));
      chk($sformatf("v%0d ram_enable", i), 32'(ram_enable), 32'(vecs[i].een));
      chk($sformatf("v%0d ram_rw", i),   32'(ram_rw),   32'(vecs[i].erw));
      chk($sformatf("v%0d ram_address", i), 32'(ram_address), 32'(vecs[i].eaddr));
      chk($sformatf("v%0d ram_din", i),  32'(ram_din),  32'(vecs[i].edin));
      chk($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].ebusy));
    end

    // Both ports requesting continuously: round-robin splits, fixed priority always picks A
    cnt_a = 0; cnt_b = 0; cnt_fa = 0; cnt_fb = 0;
    drive(1, 0, 3, 16'h0, 1, 0, 5, 16'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      cnt_a  += int'(a_gnt);
      cnt_b  += int'(b_gnt);
      cnt_fa += int'(f_a_gnt);
      cnt_fb += int'(f_b_gnt);
    end
    chk("rr a grants", 32'(cnt_a), 2);
    chk("rr b grants", 32'(cnt_b), 2);
    chk("fixed a grants", 32'(cnt_fa), 4);
    chk("fixed b grants", 32'(cnt_fb), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset during the ACCESS cycle of a read aborts it
    drive(1, 0, 3, 16'h0, 0, 0, 0, 0);
    step();
    chk("rst_mid a_gnt", 32'(a_gnt), 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_reset_state("rst_mid");
    rst = 1'b0;
    drive(1, 0, 3, 16'h0, 1, 0, 5, 16'h0);
    step();
    chk("post_rst a_gnt", 32'(a_gnt), 1);
    chk("post_rst b_gnt", 32'(b_gnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post_rst a_rvalid", 32'(a_rvalid), 1);
    chk("post_rst a_rdata", 32'(a_rdata), 32'h0000BEEF);

    // Random traffic against a reference memory updated in grant order
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
    ref_mem[3] = 16'hBEEF;
    ref_mem[5] = 16'h5A5A;
    ref_mem[7] = 16'h1234;
    tb_rr = 1'b0;
    ops = 0;
    iters = 0;
    while (ops < 1000 && iters < 4000) begin
      iters++;
      ar = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
      aa = 3'($urandom_range(0, 7)); ba = 3'($urandom_range(0, 7));
      ad = 16'($urandom); bd = 16'($urandom);
      drive(ar, aw, aa, ad, br, bw, ba, bd);
      pa = ar & (~br | tb_rr);
      pb = br & ~pa;
      step();
      chk("rnd a_gnt", 32'(a_gnt), 32'(pa));
      chk("rnd b_gnt", 32'(b_gnt), 32'(pb));
      chk("rnd en_idle", 32'(ram_enable & ~busy), 0);
      if (pa | pb) begin
        ops++;
        rd_op = pa ? ~aw : ~bw;
        exp_rd = 16'h0;
        if (rd_op) begin
          exp_rd = ref_mem[pa ? aa : ba];
        end else begin
          ref_mem[pa ? aa : ba] = pa ? ad : bd;
          chk("rnd ram_din", 32'(ram_din), 32'(pa ? ad : bd));
        end
        tb_rr = pb;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rnd en_idle", 32'(ram_enable & ~busy), 0);
        chk("rnd a_rvalid", 32'(a_rvalid), 32'(pa & rd_op));
        chk("rnd b_rvalid", 32'(b_rvalid), 32'(pb & rd_op));
        if (pa & rd_op) chk("rnd a_rdata", 32'(a_rdata), 32'(exp_rd));
        if (pb & rd_op) chk("rnd b_rdata", 32'(b_rdata), 32'(exp_rd));
      end
    end
    chk("rnd op budget", 32'(ops), 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
